bus_rr_arbiter: RTL
===================

// Module: bus_rr_arbiter
// PURPOSE
//  Shares one downstream simple valid/ready memory bus (SDRAM controller port) among N requesters.
//  Requesters are the vjtag host, test pattern generators and similar masters.
//  Round-robin grant; one transaction in flight at a time.
//  The current owner keeps the bus until its read response returns, so responses route without IDs.
//  Sits between the bus masters and the SDRAM controller, all on the system clock.
// PARAMETERS
//  N   2   number of requesters (>=2)
//  AW  24  address width
//  DW  16  data width
// PORTS
//  clk        in   1     system clock
//  rst        in   1     synchronous reset, active-high
//  m_address  in   N*AW  per-requester address, slice i = [i*AW +: AW]
//  m_wvalid   in   N     per-requester write request
//  m_wdata    in   N*DW  per-requester write data, slice i = [i*DW +: DW]
//  m_wready   out  N     write accepted (only granted bit may be 1)
//  m_rvalid   in   N     per-requester read request
//  m_rready   out  N     read accepted (only granted bit may be 1)
//  m_rrvalid  out  N     read response valid (only granted bit may be 1)
//  m_rdata    out  DW    read data, broadcast = s_rdata
//  s_address  out  AW    downstream address
//  s_wvalid   out  1     downstream write request
//  s_wdata    out  DW    downstream write data
//  s_wready   in   1     downstream write ready
//  s_rvalid   out  1     downstream read request
//  s_rready   in   1     downstream read ready
//  s_rrvalid  in   1     downstream read response valid
//  s_rdata    in   DW    downstream read data
//  grant      out  N     one-hot current owner, 0 when idle
//  rsp_err    out  1     1-cycle pulse: s_rrvalid seen outside RDWAIT
// BEHAVIOUR
//  Requester rules:
//  - Requester i requests when m_wvalid[i]|m_rvalid[i].
//  - It holds valid, address and data stable until its ready pulse.
//  - It never asserts both valids at once; if it does, write wins.
//  States: IDLE, BUSY, RDWAIT. Registers: state, grant (one-hot), last (index of previous owner).
//  IDLE:
//  - If any request, grant the first requesting index scanning last+1, last+2, ... (mod N).
//  - Register grant, set last to that index, go to BUSY. No request: stay, grant=0.
//  BUSY:
//  - s_address/s_wdata/s_wvalid/s_rvalid = granted requester's signals (combinational mux).
//  - m_wready[g]=s_wready and m_rready[g]=s_rready; all other m_*ready=0.
//  - s_wvalid&s_wready -> IDLE, grant cleared.
//  - s_rvalid&s_rready -> RDWAIT.
//  - Neither: stay; grant does not change regardless of other requests.
//  RDWAIT:
//  - s_wvalid=s_rvalid=0; m_rrvalid[g]=s_rrvalid.
//  - On s_rrvalid -> IDLE, grant cleared.
//  Latency and gaps:
//  - Request seen in IDLE at cycle 0 -> s_*valid asserted in cycle 1.
//  - Minimum one IDLE cycle between consecutive transactions, including back-to-back from one requester.
//  Outside BUSY: s_wvalid=s_rvalid=0, s_address/s_wdata=0, all m_wready/m_rready=0.
//  m_rrvalid is 0 everywhere except m_rrvalid[g] in RDWAIT.
//  s_rrvalid in IDLE/BUSY: dropped (no m_rrvalid) and rsp_err pulses next cycle (registered).
//  rsp_err registered; all other outputs combinational from state/grant and inputs.
//  Reset values: state=IDLE, grant=0, last=N-1 (requester 0 wins first), rsp_err=0, all valid/ready outputs 0.
//  Reset mid-transaction: abandon immediately. Downstream must be reset together; no response is replayed.
//  Requester dropping valid before ready is illegal; the mux simply follows the input.
// TESTING
//  1 Req0 write addr 0x000010 data 0xA5A5, s_wready=1 -> s_wvalid cycle 1 with those values; m_wready[0] 1 cycle; grant 01 -> 00.
//  2 From reset, req0 rd 0x100 and req1 rd 0x200 together; rrvalid 0x1234 then 0x5678
//    -> req0 served first; m_rrvalid[0] gets 0x1234, then m_rrvalid[1] gets 0x5678, never crossed.
//  3 Req0 and req1 each issue 4 continuous writes -> grant order 0,1,0,1,0,1,0,1, one IDLE cycle between each.
//  4 Req1 read with s_rready=0 for 5 cycles while req0 requests -> s_rvalid and address stable, grant stays req1, m_rready[0]=0.
//  5 s_rrvalid pulse in IDLE -> no m_rrvalid bit set; rsp_err high exactly 1 cycle.
//  6 rst asserted in RDWAIT -> next cycle grant=0, all valids/readies 0; next simultaneous request granted to req0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one valid/ready memory bus among N
//             requesters; the owner holds the bus until its read data returns.
//  Revision : 1.0  initial release
// ============================================================================
module bus_rr_arbiter #(
    parameter int N  = 2,
    parameter int AW = 24,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*AW-1:0] m_address,
    input  logic [N-1:0]    m_wvalid,
    input  logic [N*DW-1:0] m_wdata,
    output logic [N-1:0]    m_wready,
    input  logic [N-1:0]    m_rvalid,
    output logic [N-1:0]    m_rready,
    output logic [N-1:0]    m_rrvalid,
    output logic [DW-1:0]   m_rdata,
    output logic [AW-1:0]   s_address,
    output logic            s_wvalid,
    output logic [DW-1:0]   s_wdata,
    input  logic            s_wready,
    output logic            s_rvalid,
    input  logic            s_rready,
    input  logic            s_rrvalid,
    input  logic [DW-1:0]   s_rdata,
    output logic [N-1:0]    grant,
    output logic            rsp_err
);

    localparam int            IW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] C_LAST_RST = IW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic          rsp_err_q, rsp_err_d;

    logic [N-1:0]  w_req;
    logic          w_pick_found;
    logic [IW-1:0] w_pick_idx;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_sel_wvalid;
    logic          w_sel_rvalid;

    assign w_req = m_wvalid | m_rvalid;

    // Scan last+1, last+2, ... wrapping at N; first requester found wins.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        cand         = 0;
        cand_idx     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = cand[IW-1:0];
            if (!w_pick_found && w_req[cand_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = cand_idx;
            end
        end
    end

    // Grant is one-hot, so OR-ing the masked slices is a plain mux.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                w_sel_addr  = w_sel_addr  | m_address[i*AW +: AW];
                w_sel_wdata = w_sel_wdata | m_wdata[i*DW +: DW];
            end
        end
    end

    assign w_sel_wvalid = |(grant_q & m_wvalid);
    assign w_sel_rvalid = |(grant_q & m_rvalid);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        rsp_err_d = s_rrvalid & (state_q != ST_RDWAIT);
        s_address = '0;
        s_wdata   = '0;
        s_wvalid  = 1'b0;
        s_rvalid  = 1'b0;
        m_wready  = '0;
        m_rready  = '0;
        m_rrvalid = '0;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (w_pick_found) begin
                    grant_d[w_pick_idx] = 1'b1;
                    last_d              = w_pick_idx;
                    state_d             = ST_BUSY;
                end
            end

            ST_BUSY: begin
                s_address = w_sel_addr;
                s_wdata   = w_sel_wdata;
                s_wvalid  = w_sel_wvalid;
                // A requester asserting both valids gets its write serviced.
                s_rvalid  = w_sel_rvalid & ~w_sel_wvalid;
                m_wready  = grant_q & {N{s_wready}};
                m_rready  = grant_q & {N{s_rready}};
                if (s_wvalid && s_wready) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (s_rvalid && s_rready) begin
                    state_d = ST_RDWAIT;
                end
            end

            ST_RDWAIT: begin
                m_rrvalid = grant_q & {N{s_rrvalid}};
                if (s_rrvalid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= C_LAST_RST;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign m_rdata = s_rdata;
    assign grant   = grant_q;
    assign rsp_err = rsp_err_q;

endmodule
`default_nettype wire
